seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder.sv | 147 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back the scanned four-digit seven-segment bus,
// debounces each dwell, decodes the lit pattern to a symbol code and
// publishes a full frame once every digit position has been captured.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ssgAnode,
  input  logic [7:0]  ssg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        stall
);

  // The stability counter saturates one above the accept value, so the
  // accept value is reached exactly once per dwell.
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ACC_VAL = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SAT_VAL = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_VAL  = TW'(TIMEOUT);

  logic [11:0]   hold;
  logic [11:0]   sample;
  logic [CW-1:0] stab_cnt;
  logic [CW-1:0] stab_next;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_next;
  logic [15:0]   slot_code;
  logic [3:0]    slot_dp;
  logic [3:0]    slot_err;
  logic [3:0]    seen;
  logic [3:0]    seen_with;
  logic [3:0]    pos_bit;
  logic [1:0]    pos;
  logic          single_low;
  logic          accept;
  logic          complete;
  logic          pending;
  logic [3:0]    dec_code;
  logic          dec_err;

  // Segment pattern (a..g, active-low) to symbol code; bit 4 flags an
  // undecodable pattern, which is reported as code C.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      7'b1111110: r = 5'h0A;
      7'b1111010: r = 5'h0B;
      7'b0110000: r = 5'h0E;
      7'b1111111: r = 5'h0F;
      default:    r = 5'h1C;
    endcase
    return r;
  endfunction

  // Only a strobe with exactly one low bit names a digit position.
  always_comb begin
    single_low = 1'b1;
    pos        = 2'd0;
    case (ssgAnode)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  // Next-state of the stability filter and idle timer, plus the accept and
  // frame-completion decisions they drive.
  always_comb begin
    sample = {ssgAnode, ssg};
    if (sample != hold) begin
      stab_next = '0;
    end else if (stab_cnt == SAT_VAL) begin
      stab_next = stab_cnt;
    end else begin
      stab_next = stab_cnt + CW'(1);
    end
    accept    = single_low && (stab_next == ACC_VAL);
    pos_bit   = 4'b0001 << pos;
    seen_with = seen | pos_bit;
    complete  = accept && (seen_with == 4'hF);
    {dec_err, dec_code} = decode(ssg[7:1]);
    if (accept) begin
      idle_next = '0;
    end else if (idle_cnt == TO_VAL) begin
      idle_next = idle_cnt;
    end else begin
      idle_next = idle_cnt + TW'(1);
    end
  end

  // Filter state, slot capture, frame publication one edge after the
  // completing accept, and the stall timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= 12'hFFF;
      stab_cnt    <= '0;
      slot_code   <= 16'hFFFF;
      slot_dp     <= 4'h0;
      slot_err    <= 4'h0;
      seen        <= 4'h0;
      pending     <= 1'b0;
      digits      <= 16'hFFFF;
      dp          <= 4'h0;
      seg_err     <= 4'h0;
      frame_valid <= 1'b0;
      idle_cnt    <= '0;
      stall       <= 1'b0;
    end else begin
      hold        <= sample;
      stab_cnt    <= stab_next;
      frame_valid <= pending;
      pending     <= complete;
      if (pending) begin
        digits  <= slot_code;
        dp      <= slot_dp;
        seg_err <= slot_err;
      end
      if (accept) begin
        slot_code[{pos, 2'b00} +: 4] <= dec_code;
        slot_dp[pos]                 <= ~ssg[0];
        slot_err[pos]                <= dec_err;
        seen                         <= complete ? 4'h0 : seen_with;
      end
      idle_cnt <= idle_next;
      stall    <= (idle_next == TO_VAL);
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: drives directed and random scan sequences into two
// decoder instances (slow filter and single-sample filter) and compares
// every output each cycle against a run-length based reference model.
module tb_seg_scan_decoder;

  localparam int SC [2] = '{4, 1};
  localparam int TO [2] = '{50, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ssgAnode = 4'hF;
  logic [7:0]  ssg = 8'hFF;

  logic [15:0] digits0, digits1;
  logic [3:0]  dp0, dp1, segErr0, segErr1;
  logic        frameValid0, frameValid1, stall0, stall1;

  int checkCount = 0;
  int errorCount = 0;
  int framesSeen = 0;
  bit modelReady = 0;

  // Reference model state, one set per instance.
  logic [11:0] mPrev [2];
  int          mRun  [2];
  logic [3:0]  mCode [2][4];
  logic [3:0]  mDp   [2];
  logic [3:0]  mErr  [2];
  logic [3:0]  mSeen [2];
  bit          mPend [2];
  int          mIdle [2];
  logic [15:0] eDigits [2];
  logic [3:0]  eDp  [2];
  logic [3:0]  eErr [2];
  logic        eFv  [2];
  logic        eStall [2];

  int validCodes [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14, 15};

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT(50)) dut0 (
    .clk(clk), .rst(rst), .ssgAnode(ssgAnode), .ssg(ssg),
    .digits(digits0), .dp(dp0), .seg_err(segErr0),
    .frame_valid(frameValid0), .stall(stall0)
  );

  seg_scan_decoder #(.STABLE_CYCLES(1), .TIMEOUT(2)) dut1 (
    .clk(clk), .rst(rst), .ssgAnode(ssgAnode), .ssg(ssg),
    .digits(digits1), .dp(dp1), .seg_err(segErr1),
    .frame_valid(frameValid1), .stall(stall1)
  );

  function automatic logic [6:0] symPattern(input logic [3:0] code);
    case (code)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b1111110;
      4'hB: return 7'b1111010;
      4'hE: return 7'b0110000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] digitSsg(input logic [3:0] code, input logic dpLit);
    return {symPattern(code), ~dpLit};
  endfunction

  function automatic logic [3:0] anodeFor(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << p);
  endfunction

  task automatic modelDecode(input logic [6:0] pat, output logic [3:0] code, output logic bad);
    code = 4'hC;
    bad  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c != 12 && c != 13 && symPattern(4'(c)) == pat) begin
        code = 4'(c);
        bad  = 1'b0;
      end
    end
  endtask

  task automatic modelStep(input int i);
    logic [11:0] smp;
    bit          acc;
    int          p;
    logic [3:0]  code;
    logic        bad;
    if (rst) begin
      mPrev[i] = 12'hFFF;
      mRun[i]  = 1;
      for (int k = 0; k < 4; k++) mCode[i][k] = 4'hF;
      mDp[i] = 4'h0; mErr[i] = 4'h0; mSeen[i] = 4'h0; mPend[i] = 0; mIdle[i] = 0;
      eDigits[i] = 16'hFFFF; eDp[i] = 4'h0; eErr[i] = 4'h0; eFv[i] = 1'b0; eStall[i] = 1'b0;
      return;
    end
    smp = {ssgAnode, ssg};
    if (smp == mPrev[i]) mRun[i]++;
    else begin
      mPrev[i] = smp;
      mRun[i]  = 1;
    end
    acc = (mRun[i] == SC[i]) && ($countones(~ssgAnode) == 1);
    eFv[i] = mPend[i];
    if (mPend[i]) begin
      eDigits[i] = {mCode[i][3], mCode[i][2], mCode[i][1], mCode[i][0]};
      eDp[i]  = mDp[i];
      eErr[i] = mErr[i];
    end
    mPend[i] = 0;
    if (acc) begin
      p = 0;
      for (int k = 0; k < 4; k++) if (!ssgAnode[k]) p = k;
      modelDecode(ssg[7:1], code, bad);
      mCode[i][p] = code;
      mDp[i][p]   = ~ssg[0];
      mErr[i][p]  = bad;
      mSeen[i][p] = 1'b1;
      if (mSeen[i] == 4'hF) begin
        mPend[i] = 1;
        mSeen[i] = 4'h0;
      end
      mIdle[i] = 0;
    end else if (mIdle[i] < TO[i]) begin
      mIdle[i]++;
    end
    eStall[i] = (mIdle[i] == TO[i]);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] anode, input logic [7:0] seg, input int cycles);
    ssgAnode = anode;
    ssg      = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scanDigits(input logic [15:0] codes, input logic [3:0] dps, input int dwell);
    for (int p = 0; p < 4; p++) applyStimulus(anodeFor(p), digitSsg(codes[4*p +: 4], dps[p]), dwell);
  endtask

  task automatic glitchScan(input logic [15:0] codes, input int g0, input int g1, input int g2, input int g3);
    int gl [4];
    gl = '{g0, g1, g2, g3};
    for (int p = 0; p < 4; p++) begin
      applyStimulus(anodeFor(p), 8'h01, gl[p]);
      applyStimulus(anodeFor(p), digitSsg(codes[4*p +: 4], 1'b0), 10 - gl[p]);
    end
  endtask

  // Advance the reference model on every active edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) modelStep(i);
    modelReady = 1;
  end

  // Compare every output of both instances with the model mid-cycle.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("dut0.digits", digits0, eDigits[0]);
      checkOutput("dut0.dp", 16'(dp0), 16'(eDp[0]));
      checkOutput("dut0.seg_err", 16'(segErr0), 16'(eErr[0]));
      checkOutput("dut0.frame_valid", 16'(frameValid0), 16'(eFv[0]));
      checkOutput("dut0.stall", 16'(stall0), 16'(eStall[0]));
      checkOutput("dut1.digits", digits1, eDigits[1]);
      checkOutput("dut1.dp", 16'(dp1), 16'(eDp[1]));
      checkOutput("dut1.seg_err", 16'(segErr1), 16'(eErr[1]));
      checkOutput("dut1.frame_valid", 16'(frameValid1), 16'(eFv[1]));
      checkOutput("dut1.stall", 16'(stall1), 16'(eStall[1]));
      if (frameValid0 === 1'b1) framesSeen++;
    end
  end

  // Directed scenarios followed by a randomized scan stream.
  initial begin
    int n;
    int r;
    @(negedge clk);
    rst = 1'b1;
    scanDigits(16'h1234, 4'hF, 4);
    checkOutput("reset.digits", digits0, 16'hFFFF);
    checkOutput("reset.dp", 16'(dp0), 16'h0);
    checkOutput("reset.seg_err", 16'(segErr0), 16'h0);
    checkOutput("reset.stall", 16'(stall0), 16'h0);
    checkOutput("reset.frames", 16'(framesSeen), 16'd0);
    rst = 1'b0;

    $display("[TB] basic scan");
    scanDigits(16'h3210, 4'b0010, 10);
    checkOutput("scan.digits", digits0, 16'h3210);
    checkOutput("scan.dp", 16'(dp0), 16'h2);
    checkOutput("scan.seg_err", 16'(segErr0), 16'h0);
    checkOutput("scan.frames", 16'(framesSeen), 16'd1);

    $display("[TB] glitch scans");
    glitchScan(16'h3210, 3, 3, 3, 3);
    checkOutput("glitch3.digits", digits0, 16'h3210);
    checkOutput("glitch3.frames", 16'(framesSeen), 16'd2);
    glitchScan(16'h3210, 3, 3, 3, 4);
    checkOutput("glitch4.digits", digits0, 16'h8210);
    checkOutput("glitch4.frames", 16'(framesSeen), 16'd3);

    $display("[TB] error screens");
    applyStimulus(4'b0111, 8'b01100001, 10);
    applyStimulus(4'b1011, 8'b11110101, 10);
    applyStimulus(4'b1101, 8'b11110101, 10);
    applyStimulus(4'b1110, 8'b00000010, 10);
    checkOutput("err.digits", digits0, 16'hEBB0);
    checkOutput("err.dp", 16'(dp0), 16'h1);
    checkOutput("err.frames", 16'(framesSeen), 16'd4);
    applyStimulus(4'b1110, 8'b00000011, 10);
    applyStimulus(4'b1101, 8'b11111101, 10);
    applyStimulus(4'b1011, 8'b10101011, 10);
    applyStimulus(4'b0111, 8'b11111111, 10);
    checkOutput("bad.digits", digits0, 16'hFCA0);
    checkOutput("bad.seg_err", 16'(segErr0), 16'h4);
    checkOutput("bad.frames", 16'(framesSeen), 16'd5);

    $display("[TB] invalid anodes");
    applyStimulus(anodeFor(0), digitSsg(4'h4, 1'b0), 10);
    applyStimulus(anodeFor(1), digitSsg(4'h5, 1'b0), 10);
    applyStimulus(4'b1111, digitSsg(4'h9, 1'b0), 50);
    applyStimulus(4'b1100, digitSsg(4'h9, 1'b0), 50);
    checkOutput("invalid.frames", 16'(framesSeen), 16'd5);
    applyStimulus(anodeFor(2), digitSsg(4'h6, 1'b0), 10);
    applyStimulus(anodeFor(3), digitSsg(4'h7, 1'b0), 10);
    checkOutput("invalid.digits", digits0, 16'h7654);
    checkOutput("invalid.frames2", 16'(framesSeen), 16'd6);

    $display("[TB] reset mid-frame");
    applyStimulus(anodeFor(0), digitSsg(4'h9, 1'b0), 10);
    applyStimulus(anodeFor(1), digitSsg(4'h8, 1'b0), 10);
    applyStimulus(anodeFor(2), digitSsg(4'h7, 1'b0), 10);
    rst = 1'b1;
    applyStimulus(anodeFor(2), digitSsg(4'h7, 1'b0), 3);
    checkOutput("midrst.digits", digits0, 16'hFFFF);
    rst = 1'b0;
    scanDigits(16'h4321, 4'h0, 10);
    checkOutput("midrst.scan", digits0, 16'h4321);
    checkOutput("midrst.frames", 16'(framesSeen), 16'd7);

    $display("[TB] stall timing");
    ssgAnode = anodeFor(0);
    ssg      = digitSsg(4'h5, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall0 !== 1'b1 && n < 200);
    checkOutput("stall.rise", 16'(n), 16'd54);
    ssgAnode = anodeFor(1);
    ssg      = digitSsg(4'h6, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall0 !== 1'b0 && n < 20);
    checkOutput("stall.drop", 16'(n), 16'd4);

    $display("[TB] random scans");
    for (int d = 0; d < 400; d++) begin
      rst = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 9);
      if (r < 8) ssgAnode = anodeFor(r % 4);
      else       ssgAnode = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) ssg = 8'($urandom);
      else ssg = digitSsg(4'(validCodes[$urandom_range(0, 13)]), 1'($urandom));
      repeat ($urandom_range(1, 7)) @(negedge clk);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
